// File: rtl/qpu_ifu_ir_stage_pkg.sv
// Shared IFU/decoder definitions: sizes, branch opcode, B-immediate field layout.
package qpu_ifu_ir_stage_pkg;

   localparam int unsigned QPU_PC_SIZE    = 32;
   localparam int unsigned QPU_INSTR_SIZE = 32;

   // Classical branch major opcode and quantum flag location
   localparam logic [3:0]  QPU_OPC_BRANCH = 4'b1000;
   localparam int unsigned QPU_QFLAG_BIT  = 0;
   localparam int unsigned QPU_OPC_LSB    = 1;
   localparam int unsigned QPU_OPC_MSB    = 4;

   // B-immediate field slices (bit 9 doubles as the sign bit)
   localparam int unsigned QPU_BIMM_HI_LSB = 5;
   localparam int unsigned QPU_BIMM_HI_MSB = 9;
   localparam int unsigned QPU_BIMM_LO_LSB = 15;
   localparam int unsigned QPU_BIMM_LO_MSB = 23;
   localparam int unsigned QPU_BIMM_W      = (QPU_BIMM_HI_MSB - QPU_BIMM_HI_LSB + 1)
                                           + (QPU_BIMM_LO_MSB - QPU_BIMM_LO_LSB + 1) + 2;
   localparam int unsigned QPU_BIMM_SEXT   = QPU_PC_SIZE - QPU_BIMM_W;

   // IR payload presented to the EXU
   typedef struct packed {
      logic [QPU_INSTR_SIZE-1:0] ir;
      logic [QPU_PC_SIZE-1:0]    pc;
      logic                      prdt_taken;
   } qpu_ifu_ir_t;

   // Sign-extended, word-aligned branch offset
   function automatic logic [QPU_PC_SIZE-1:0] qpu_bimm(input logic [QPU_INSTR_SIZE-1:0] instr);
      return {{QPU_BIMM_SEXT{instr[QPU_BIMM_HI_MSB]}},
              instr[QPU_BIMM_HI_MSB:QPU_BIMM_HI_LSB],
              instr[QPU_BIMM_LO_MSB:QPU_BIMM_LO_LSB],
              2'b00};
   endfunction

endpackage

// File: rtl/qpu_ifu_ir_stage_predecode.sv
// Combinational branch pre-decode: static backward-taken prediction and next fetch PC.
module qpu_ifu_predecode
   import qpu_ifu_ir_stage_pkg::*;
(
   input  logic [QPU_INSTR_SIZE-1:0] instr_i,
   input  logic [QPU_PC_SIZE-1:0]    pc_i,
   output logic                      is_bxx_c,
   output logic                      taken_c,
   output logic [QPU_PC_SIZE-1:0]    next_pc_c
);

   // Classical branch detect; negative offset (backward) predicts taken
   always_comb begin
      is_bxx_c  = (instr_i[QPU_QFLAG_BIT] == 1'b0) &&
                  (instr_i[QPU_OPC_MSB:QPU_OPC_LSB] == QPU_OPC_BRANCH);
      taken_c   = is_bxx_c & instr_i[QPU_BIMM_HI_MSB];
      next_pc_c = pc_i + (taken_c ? qpu_bimm(instr_i) : QPU_PC_SIZE'(4));
   end

endmodule

// File: rtl/qpu_ifu_ir_stage.sv
// Instruction fetch / IR stage: single-outstanding fetch, IR capture, EXU handshake, flush redirect.
module qpu_ifu_ir_stage
   import qpu_ifu_ir_stage_pkg::*;
#(
   parameter logic [QPU_PC_SIZE-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   output logic                      ifu_req_valid,
   input  logic                      ifu_req_ready,
   output logic [QPU_PC_SIZE-1:0]    ifu_req_addr,
   input  logic                      ifu_rsp_valid,
   output logic                      ifu_rsp_ready,
   input  logic [QPU_INSTR_SIZE-1:0] ifu_rsp_instr,
   output logic                      ifu_o_valid,
   input  logic                      ifu_o_ready,
   output logic [QPU_INSTR_SIZE-1:0] ifu_o_ir,
   output logic [QPU_PC_SIZE-1:0]    ifu_o_pc,
   output logic                      ifu_o_prdt_taken,
   input  logic                      pipe_flush_req,
   input  logic [QPU_PC_SIZE-1:0]    pipe_flush_pc
);

   logic [QPU_PC_SIZE-1:0] fetch_pc_q, fetch_pc_d;
   logic [QPU_PC_SIZE-1:0] req_pc_q, req_pc_d;
   logic                   outstanding_q, outstanding_d;
   logic                   discard_q, discard_d;
   logic                   ir_valid_q, ir_valid_d;
   qpu_ifu_ir_t            ir_q, ir_d;

   logic                   req_hs_c, rsp_hs_c, exu_hs_c;
   logic                   rsp_is_bxx, rsp_taken;
   logic [QPU_PC_SIZE-1:0] rsp_next_pc;
   logic                   unused_bits;

   qpu_ifu_predecode u_predecode (
      .instr_i   (ifu_rsp_instr),
      .pc_i      (req_pc_q),
      .is_bxx_c  (rsp_is_bxx),
      .taken_c   (rsp_taken),
      .next_pc_c (rsp_next_pc)
   );

   assign unused_bits = ^{pipe_flush_pc[1:0], rsp_is_bxx};

   // Handshake qualifiers; everything is held low while reset is asserted
   always_comb begin
      ifu_req_valid    = rst_n & ~outstanding_q & (~ir_valid_q | ifu_o_ready) & ~pipe_flush_req;
      ifu_req_addr     = fetch_pc_q;
      ifu_rsp_ready    = rst_n & outstanding_q;
      ifu_o_valid      = rst_n & ir_valid_q & ~pipe_flush_req;
      ifu_o_ir         = ir_q.ir;
      ifu_o_pc         = ir_q.pc;
      ifu_o_prdt_taken = ir_q.prdt_taken;
      req_hs_c         = ifu_req_valid & ifu_req_ready;
      rsp_hs_c         = ifu_rsp_valid & ifu_rsp_ready;
      exu_hs_c         = ifu_o_valid & ifu_o_ready;
   end

   // Next-state: request, response, EXU consume, then flush overrides
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      req_pc_d      = req_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      ir_valid_d    = ir_valid_q;
      ir_d          = ir_q;

      if (exu_hs_c) begin
         ir_valid_d = 1'b0;
      end

      if (req_hs_c) begin
         outstanding_d = 1'b1;
         req_pc_d      = fetch_pc_q;
      end

      if (rsp_hs_c) begin
         outstanding_d = 1'b0;
         if (discard_q) begin
            discard_d = 1'b0;
         end else if (!pipe_flush_req) begin
            ir_d.ir         = ifu_rsp_instr;
            ir_d.pc         = req_pc_q;
            ir_d.prdt_taken = rsp_taken;
            ir_valid_d      = 1'b1;
            fetch_pc_d      = rsp_next_pc;
         end
      end

      if (pipe_flush_req) begin
         ir_valid_d = 1'b0;
         fetch_pc_d = {pipe_flush_pc[QPU_PC_SIZE-1:2], 2'b00};
         if (outstanding_q && !rsp_hs_c) begin
            discard_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         req_pc_q      <= RESET_PC;
         outstanding_q <= 1'b0;
         discard_q     <= 1'b0;
         ir_valid_q    <= 1'b0;
         ir_q          <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         req_pc_q      <= req_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         ir_valid_q    <= ir_valid_d;
         ir_q          <= ir_d;
      end
   end

endmodule
